// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with an 8-deep byte FIFO and drain interrupt.
// Register writes land on the ce&we edge; reads are combinational; pushes to a full FIFO drop and flag ovf.

module fifo #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign pop_ok   = pop && !empty;
    // Fullness is judged before the pop, so a simultaneous pop frees the slot for this push.
    assign push_ok  = push && (!full || pop_ok);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

module uart_tx_mmio #(
    parameter int          FIFO_AW   = 3,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        int_o
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [1:0] REG_TXDATA  = 2'b00;
    localparam logic [1:0] REG_STATUS  = 2'b01;
    localparam logic [1:0] REG_DIVISOR = 2'b10;
    localparam logic [1:0] REG_CTRL    = 2'b11;

    state_t       state, state_nxt;
    logic [15:0]  divisor;
    logic         tx_en;
    logic         irq_en;
    logic         ovf;
    logic [15:0]  div_q, div_q_nxt;
    logic [15:0]  baud_cnt, baud_cnt_nxt;
    logic [2:0]   bit_idx, bit_idx_nxt;
    logic [7:0]   shreg, shreg_nxt;
    logic         tx_q, tx_nxt;
    logic         int_q;
    logic [15:0]  div_eff;
    logic         wr_en;
    logic         rd_en;
    logic [1:0]   reg_idx;
    logic         push;
    logic         pop;
    logic         load;
    logic         start_ok;
    logic         busy;
    logic [7:0]   head;
    logic [FIFO_AW:0] count;
    logic [3:0]   count_rd;
    logic         empty;
    logic         full;
    logic         unused_bits;

    assign wr_en    = ce & we;
    assign rd_en    = ce & ~we;
    assign reg_idx  = addr[3:2];
    assign push     = wr_en && (reg_idx == REG_TXDATA) && sel[0];
    assign busy     = (state != IDLE);
    assign start_ok = tx_en && !empty;
    assign div_eff  = (divisor == 16'd0) ? 16'd1 : divisor;
    assign count_rd = 4'(count);
    assign tx_o     = tx_q;
    assign int_o    = int_q;
    assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:16], sel[3:2]};

    fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (data_i[7:0]),
        .pop      (pop),
        .head_dat (head),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor <= DIV_RESET;
            tx_en   <= 1'b0;
            irq_en  <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (wr_en && reg_idx == REG_DIVISOR) begin
                if (sel[0]) divisor[7:0]  <= data_i[7:0];
                if (sel[1]) divisor[15:8] <= data_i[15:8];
            end
            if (wr_en && reg_idx == REG_CTRL && sel[0]) begin
                tx_en  <= data_i[0];
                irq_en <= data_i[1];
            end
            // A dropped byte outranks a same-edge clear so no overflow goes unreported.
            if (push && full && !pop) begin
                ovf <= 1'b1;
            end else if (wr_en && reg_idx == REG_STATUS && sel[0] && data_i[3]) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        data_o = 32'd0;
        if (rd_en) begin
            case (reg_idx)
                REG_STATUS:  data_o = {24'd0, count_rd, ovf, busy, empty, full};
                REG_DIVISOR: data_o = {16'd0, divisor};
                REG_CTRL:    data_o = {30'd0, irq_en, tx_en};
                default:     data_o = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_q    <= 16'd1;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            tx_q     <= 1'b1;
            int_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            div_q    <= div_q_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            tx_q     <= tx_nxt;
            int_q    <= irq_en & empty & ~busy;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_q_nxt    = div_q;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        tx_nxt       = tx_q;
        pop          = 1'b0;
        load         = 1'b0;

        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (start_ok) load = 1'b1;
            end
            START: begin
                if (baud_cnt == 16'd0) begin
                    state_nxt    = DATA;
                    baud_cnt_nxt = div_q - 16'd1;
                    bit_idx_nxt  = 3'd0;
                    tx_nxt       = shreg[0];
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_nxt = div_q - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shreg_nxt   = {1'b0, shreg[7:1]};
                        tx_nxt      = shreg[1];
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
            STOP: begin
                if (baud_cnt == 16'd0) begin
                    // Chain straight into the next START so queued bytes go out without an idle gap.
                    if (start_ok) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase

        if (load) begin
            pop          = 1'b1;
            shreg_nxt    = head;
            div_q_nxt    = div_eff;
            baud_cnt_nxt = div_eff - 16'd1;
            bit_idx_nxt  = 3'd0;
            state_nxt    = START;
            tx_nxt       = 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: line waveform compared against a frame-level model of 8N1 serialisation.
module tb_uart_tx_mmio;
    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        tx_o;
    logic        int_o;

    int checks = 0;
    int errors = 0;

    logic cap[$];
    logic bcap[$];
    logic exp_q[$];

    uart_tx_mmio dut (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce),
        .we     (we),
        .addr   (addr),
        .sel    (sel),
        .data_i (data_i),
        .data_o (data_o),
        .tx_o   (tx_o),
        .int_o  (int_o)
    );

    always #5 clk = ~clk;

    task automatic bus_idle();
        ce = 1'b0; we = 1'b0; addr = 32'd0; sel = 4'd0; data_i = 32'd0;
    endtask

    // All bus tasks start and end on a falling edge; a write lands on the rising edge in between.
    task automatic wr(input logic [1:0] r, input logic [3:0] s, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = {28'd0, r, 2'b00}; sel = s; data_i = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = {28'd0, r, 2'b00}; sel = 4'hF; data_i = 32'd0;
        #1 d = data_o;
        bus_idle();
    endtask

    task automatic push(input logic [7:0] b);
        wr(2'b00, 4'b0001, {24'd0, b});
    endtask

    task automatic clear_caps();
        cap.delete(); bcap.delete(); exp_q.delete();
    endtask

    // Sample tx and the STATUS busy bit once per cycle, holding a STATUS read on the bus.
    task automatic record(input int n);
        ce = 1'b1; we = 1'b0; addr = 32'h4; sel = 4'hF;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap.push_back(tx_o);
            bcap.push_back(data_o[2]);
        end
        bus_idle();
    endtask

    // Reference line for one frame: start bit, 8 data bits LSB first, stop bit, each d clocks.
    task automatic model_frame(input logic [7:0] b, input int d);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < d; j++) begin
                if (k == 0)      exp_q.push_back(1'b0);
                else if (k == 9) exp_q.push_back(1'b1);
                else             exp_q.push_back(b[k-1]);
            end
        end
    endtask

    function automatic int wave_mismatch();
        int m = 0;
        logic e;
        for (int i = 0; i < cap.size(); i++) begin
            e = (i < exp_q.size()) ? exp_q[i] : 1'b1;
            if (cap[i] !== e) m++;
        end
        return m;
    endfunction

    function automatic int busy_count();
        int c = 0;
        for (int i = 0; i < bcap.size(); i++) if (bcap[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b want=1", tx_o); end
        checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL reset_int got=%b want=0", int_o); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (data_o !== 32'd0) begin errors++; $display("FAIL reset_data_o got=%h want=0", data_o); end
        rd(2'b01, v);
        checks++; if (v !== 32'h02) begin errors++; $display("FAIL reset_status got=%h want=02", v); end
        rd(2'b10, v);
        checks++; if (v !== 32'd434) begin errors++; $display("FAIL reset_divisor got=%0d want=434", v); end
        rd(2'b11, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_ctrl got=%h want=0", v); end
    endtask

    task automatic test_regs();
        logic [31:0] v;
        wr(2'b10, 4'b0001, 32'h1234ABCD);
        rd(2'b10, v);
        checks++; if (v !== 32'h01CD) begin errors++; $display("FAIL div_lane0 got=%h want=01cd", v); end
        wr(2'b10, 4'b0010, 32'h1234ABCD);
        rd(2'b10, v);
        checks++; if (v !== 32'hABCD) begin errors++; $display("FAIL div_lane1 got=%h want=abcd", v); end
        wr(2'b11, 4'b1110, 32'h3);
        rd(2'b11, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL ctrl_no_sel0 got=%h want=0", v); end
        wr(2'b11, 4'b0001, 32'h2);
        rd(2'b11, v);
        checks++; if (v !== 32'd2) begin errors++; $display("FAIL ctrl_write got=%h want=2", v); end
        wr(2'b11, 4'b0001, 32'h0);
        rd(2'b00, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL txdata_read got=%h want=0", v); end
        ce = 1'b1; we = 1'b1; addr = 32'h8; sel = 4'd0;
        #1 v = data_o;
        bus_idle();
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL data_o_on_write got=%h want=0", v); end
    endtask

    task automatic test_single_frame();
        int m;
        int bc;
        wr(2'b10, 4'b0011, 32'd4);
        wr(2'b11, 4'b0001, 32'd1);
        clear_caps();
        push(8'h55);
        record(44);
        model_frame(8'h55, 4);
        m = wave_mismatch();
        checks++; if (m != 0) begin errors++; $display("FAIL single_wave mismatches=%0d want=0", m); end
        bc = busy_count();
        checks++; if (bc != 40) begin errors++; $display("FAIL single_busy got=%0d want=40", bc); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        int m;
        wr(2'b11, 4'b0001, 32'd0);
        for (int i = 1; i <= 9; i++) push(8'(i));
        rd(2'b01, v);
        checks++; if (v !== 32'h89) begin errors++; $display("FAIL ovf_status got=%h want=89", v); end
        wr(2'b01, 4'b0001, 32'h00);
        rd(2'b01, v);
        checks++; if (v !== 32'h89) begin errors++; $display("FAIL ovf_w0_keeps got=%h want=89", v); end
        wr(2'b01, 4'b0001, 32'h08);
        rd(2'b01, v);
        checks++; if (v !== 32'h81) begin errors++; $display("FAIL ovf_clear got=%h want=81", v); end
        clear_caps();
        wr(2'b11, 4'b0001, 32'd1);
        record(325);
        for (int i = 1; i <= 8; i++) model_frame(8'(i), 4);
        m = wave_mismatch();
        checks++; if (m != 0) begin errors++; $display("FAIL ovf_drain_wave mismatches=%0d want=0", m); end
        rd(2'b01, v);
        checks++; if (v !== 32'h02) begin errors++; $display("FAIL ovf_after_status got=%h want=02", v); end
    endtask

    task automatic test_back_to_back();
        int m;
        int bc;
        wr(2'b11, 4'b0001, 32'd0);
        wr(2'b10, 4'b0011, 32'd2);
        push(8'hA0);
        push(8'h0F);
        clear_caps();
        wr(2'b11, 4'b0001, 32'd1);
        record(44);
        model_frame(8'hA0, 2);
        model_frame(8'h0F, 2);
        m = wave_mismatch();
        checks++; if (m != 0) begin errors++; $display("FAIL b2b_wave mismatches=%0d want=0", m); end
        bc = busy_count();
        checks++; if (bc != 40 || bcap[39] !== 1'b1) begin
            errors++; $display("FAIL b2b_busy got=%0d want=40 contiguous", bc);
        end
    endtask

    task automatic test_irq();
        int first;
        wr(2'b11, 4'b0001, 32'd3);
        checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL irq_latency got=%b want=0", int_o); end
        @(negedge clk);
        checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL irq_empty got=%b want=1", int_o); end
        push(8'h41);
        first = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) begin
                checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL irq_clear_on_push got=%b want=0", int_o); end
            end
            if (first < 0 && int_o === 1'b1) first = n;
        end
        checks++; if (first != 22) begin errors++; $display("FAIL irq_rise_cycle got=%0d want=22", first); end
        wr(2'b11, 4'b0001, 32'd1);
        @(negedge clk);
        checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL irq_disable got=%b want=0", int_o); end
    endtask

    task automatic test_div_change();
        logic [7:0] b1;
        logic [7:0] b2;
        int m;
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        wr(2'b11, 4'b0001, 32'd0);
        wr(2'b10, 4'b0011, 32'd0);
        push(b1);
        push(b2);
        clear_caps();
        wr(2'b11, 4'b0001, 32'd1);
        for (int t = 1; t <= 95; t++) begin
            @(negedge clk);
            cap.push_back(tx_o);
            if (t == 2) begin
                ce = 1'b1; we = 1'b1; addr = 32'h8; sel = 4'b0011; data_i = 32'd8;
            end else begin
                bus_idle();
            end
        end
        bus_idle();
        model_frame(b1, 1);
        model_frame(b2, 8);
        m = wave_mismatch();
        checks++; if (m != 0) begin errors++; $display("FAIL divchg_wave mismatches=%0d want=0 b1=%h b2=%h", m, b1, b2); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] v;
        wr(2'b11, 4'b0001, 32'd0);
        wr(2'b10, 4'b0011, 32'd4);
        push(8'h00);
        push(8'hFF);
        wr(2'b11, 4'b0001, 32'd1);
        repeat (10) @(negedge clk);
        checks++; if (tx_o !== 1'b0) begin errors++; $display("FAIL rstmid_pre_tx got=%b want=0", tx_o); end
        rst = 1'b1;
        #1;
        checks++; if (tx_o !== 1'b1) begin errors++; $display("FAIL rstmid_async_tx got=%b want=1", tx_o); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(2'b01, v);
        checks++; if (v !== 32'h02) begin errors++; $display("FAIL rstmid_status got=%h want=02", v); end
        rd(2'b10, v);
        checks++; if (v !== 32'd434) begin errors++; $display("FAIL rstmid_divisor got=%0d want=434", v); end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [3:0]  s;
        int d_raw;
        int d;
        int n;
        int m;
        int bc;
        for (int it = 0; it < 4; it++) begin
            q.delete();
            d_raw = int'($urandom_range(0, 3));
            d = (d_raw == 0) ? 1 : d_raw;
            n = int'($urandom_range(1, 8));
            wr(2'b11, 4'b0001, 32'd0);
            wr(2'b10, 4'b0011, 32'(d_raw));
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                s = 4'($urandom);
                wr(2'b00, s, {24'd0, b});
                if (s[0]) q.push_back(b);
            end
            rd(2'b01, v);
            checks++; if (v[7:4] !== 4'(q.size()) || v[1] !== (q.size() == 0)) begin
                errors++; $display("FAIL rand_count it=%0d got=%h want_count=%0d", it, v, q.size());
            end
            clear_caps();
            wr(2'b11, 4'b0001, 32'd1);
            record(10 * d * n + 4);
            foreach (q[k]) model_frame(q[k], d);
            m = wave_mismatch();
            checks++; if (m != 0) begin errors++; $display("FAIL rand_wave it=%0d mismatches=%0d want=0 d=%0d", it, m, d); end
            bc = busy_count();
            checks++; if (bc != 10 * d * q.size()) begin
                errors++; $display("FAIL rand_busy it=%0d got=%0d want=%0d", it, bc, 10 * d * q.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_irq();
        test_div_change();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
